// File: rtl/vga_pkg.sv
// Shared VGA/text-path definitions: character constants and text command encoding.
package vga_pkg;

  localparam int unsigned CHAR_W  = 7;
  localparam int unsigned ADDR_W  = 8;
  localparam int unsigned DEPTH   = 256;

  localparam logic [CHAR_W-1:0] SPACE = 7'h20;

  // Text stream command carried alongside each write request.
  typedef enum logic [1:0] {
    TXT_CHAR = 2'd0,
    TXT_BS   = 2'd1,
    TXT_NL   = 2'd2,
    TXT_CLR  = 2'd3
  } txt_cmd_t;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } tb_state_t;

endpackage

// File: rtl/text_buffer_ram.sv
// 256x7 single-write/single-read RAM, registered read-first output, array not reset.
//   clk, rst           : clock, async active-high reset (read register only)
//   we, waddr, wdata   : write port
//   raddr, rdata       : read address, registered read data (1 clk latency)
module text_buffer_ram
  import vga_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [CHAR_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [CHAR_W-1:0] rdata
);

  logic [CHAR_W-1:0] mem [DEPTH];
  logic [CHAR_W-1:0] rd_d;
  logic [CHAR_W-1:0] rd_q;

  // Combinational array read sampled before this edge's write: read-first.
  always_comb begin
    rd_d = mem[raddr];
  end

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q <= '0;
    end else begin
      rd_q <= rd_d;
    end
  end

  assign rdata = rd_q;

endmodule

// File: rtl/menu_text_buffer.sv
// Writable 16x16 character screen buffer with managed cursor and clear sweep.
//   clk, rst              : clock, async active-high reset
//   char_xy / char_code   : renderer read port, [7:4] row [3:0] col, 1 clk latency
//   wr_valid/ready/cmd/code : command stream (CHAR, BS, NL, CLR)
//   cursor_xy, full, busy : cursor position, last-cell-written flag, sweep active
module menu_text_buffer
  import vga_pkg::*;
#(
  parameter logic [6:0] CLEAR_CODE = SPACE
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] char_xy,
  output logic [6:0] char_code,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [1:0] wr_cmd,
  input  logic [6:0] wr_code,
  output logic [7:0] cursor_xy,
  output logic       full,
  output logic       busy
);

  localparam int unsigned CLR_CYCLES = DEPTH;

  tb_state_t   state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [7:0]  cursor_q, cursor_d;
  logic        full_q, full_d;
  logic        busy_q, busy_d;
  logic        ready_q, ready_d;

  logic        we_c;
  logic [7:0]  waddr_c;
  logic [6:0]  wdata_c;
  txt_cmd_t    cmd_c;
  logic        accept_c;

  assign cmd_c    = txt_cmd_t'(wr_cmd);
  assign accept_c = wr_valid && ready_q;

  // Next-state, cursor update and RAM write decode.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cursor_d = cursor_q;
    full_d   = full_q;
    we_c     = 1'b0;
    waddr_c  = cursor_q;
    wdata_c  = CLEAR_CODE;

    case (state_q)
      ST_CLEAR: begin
        we_c    = 1'b1;
        waddr_c = cnt_q;
        if (cnt_q == 8'(CLR_CYCLES - 1)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      ST_IDLE: begin
        if (accept_c) begin
          case (cmd_c)
            TXT_CHAR: begin
              if (!full_q) begin
                we_c    = 1'b1;
                wdata_c = wr_code;
                // Last cell parks the cursor and raises full instead of wrapping.
                if (cursor_q == 8'hFF) begin
                  full_d = 1'b1;
                end else begin
                  cursor_d = cursor_q + 8'd1;
                end
              end
            end
            TXT_BS: begin
              if (full_q) begin
                we_c    = 1'b1;
                waddr_c = 8'hFF;
                full_d  = 1'b0;
              end else if (cursor_q != 8'h00) begin
                we_c     = 1'b1;
                waddr_c  = cursor_q - 8'd1;
                cursor_d = cursor_q - 8'd1;
              end
            end
            TXT_NL: begin
              if (!full_q && (cursor_q[7:4] != 4'hF)) begin
                cursor_d = {cursor_q[7:4] + 4'd1, 4'h0};
              end
            end
            TXT_CLR: begin
              cursor_d = '0;
              full_d   = 1'b0;
              cnt_d    = '0;
              state_d  = ST_CLEAR;
            end
            default: ;
          endcase
        end
      end

      default: state_d = ST_CLEAR;
    endcase

    busy_d  = (state_d == ST_CLEAR);
    ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_CLEAR;
      cnt_q    <= '0;
      cursor_q <= '0;
      full_q   <= 1'b0;
      busy_q   <= 1'b1;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      cursor_q <= cursor_d;
      full_q   <= full_d;
      busy_q   <= busy_d;
      ready_q  <= ready_d;
    end
  end

  text_buffer_ram u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (we_c),
    .waddr (waddr_c),
    .wdata (wdata_c),
    .raddr (char_xy),
    .rdata (char_code)
  );

  assign cursor_xy = cursor_q;
  assign full      = full_q;
  assign busy      = busy_q;
  assign wr_ready  = ready_q;

endmodule

// File: tb/tb_menu_text_buffer.sv
// Directed bench for menu_text_buffer: read results checked through a scoreboard queue.
module tb_menu_text_buffer;
  import vga_pkg::*;

  logic       clk;
  logic       rst;
  logic [7:0] char_xy;
  logic [6:0] char_code;
  logic       wr_valid;
  logic       wr_ready;
  logic [1:0] wr_cmd;
  logic [6:0] wr_code;
  logic [7:0] cursor_xy;
  logic       full;
  logic       busy;

  int n_tests = 0;
  int n_fail  = 0;
  logic [6:0] exp_q [$];

  menu_text_buffer dut (
    .clk       (clk),
    .rst       (rst),
    .char_xy   (char_xy),
    .char_code (char_code),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_cmd    (wr_cmd),
    .wr_code   (wr_code),
    .cursor_xy (cursor_xy),
    .full      (full),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [6:0] code_of(input int a);
    logic [7:0] av;
    av = 8'(a);
    return av[6:0] ^ 7'h55;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Issue a read, expected value queued now and retired when the data appears.
  task automatic rd(input logic [7:0] addr, input logic [6:0] expv, input string tag);
    exp_q.push_back(expv);
    char_xy = addr;
    tick();
    chk(tag, 32'(char_code), 32'(exp_q.pop_front()));
  endtask

  task automatic send(input txt_cmd_t cmd, input logic [6:0] code);
    wr_valid = 1'b1;
    wr_cmd   = cmd;
    wr_code  = code;
    tick();
    wr_valid = 1'b0;
    wr_code  = 7'h00;
  endtask

  // Cycles spent with busy high, bounded; pulses wr_valid CHAR requests meanwhile.
  task automatic count_busy(input bit poke, output int n);
    n = 0;
    while (busy === 1'b1 && n < 400) begin
      wr_valid = poke && n[0];
      wr_cmd   = TXT_CHAR;
      wr_code  = 7'h5A;
      tick();
      n++;
    end
    wr_valid = 1'b0;
  endtask

  initial begin
    int n;
    rst      = 1'b0;
    char_xy  = 8'h00;
    wr_valid = 1'b0;
    wr_cmd   = 2'd0;
    wr_code  = 7'h00;
    #1 rst = 1'b1;
    #1;
    chk("rst_char_code", 32'(char_code), 0);
    chk("rst_cursor", 32'(cursor_xy), 0);
    chk("rst_full", 32'(full), 0);
    chk("rst_busy", 32'(busy), 1);
    chk("rst_ready", 32'(wr_ready), 0);
    @(posedge clk); #1 rst = 1'b0;

    count_busy(1'b0, n);
    chk("init_sweep_len", 32'(n), 256);
    chk("init_ready", 32'(wr_ready), 1);
    rd(8'h00, SPACE, "init_rd_00");
    rd(8'h7F, SPACE, "init_rd_7F");
    rd(8'hFF, SPACE, "init_rd_FF");

    // Basic writes and read-first behaviour on the same address.
    send(TXT_CHAR, 7'h41);
    chk("cur_after_A", 32'(cursor_xy), 8'h01);
    char_xy = 8'h01;
    exp_q.push_back(SPACE);
    send(TXT_CHAR, 7'h42);
    chk("rd_during_wr", 32'(char_code), 32'(exp_q.pop_front()));
    chk("cur_after_B", 32'(cursor_xy), 8'h02);
    rd(8'h00, 7'h41, "rd_A");
    rd(8'h01, 7'h42, "rd_B");

    // Row wrap, newline, backspace across the row boundary.
    for (int a = 2; a < 'h0F; a++) send(TXT_CHAR, 7'h30);
    chk("cur_0F", 32'(cursor_xy), 8'h0F);
    send(TXT_CHAR, 7'h5A);
    chk("cur_wrap_10", 32'(cursor_xy), 8'h10);
    rd(8'h0F, 7'h5A, "rd_Z");
    send(TXT_NL, 7'h7F);
    chk("cur_nl_20", 32'(cursor_xy), 8'h20);
    send(TXT_BS, 7'h7F);
    chk("cur_bs_1F", 32'(cursor_xy), 8'h1F);
    rd(8'h1F, SPACE, "rd_bs_1F");

    // Fill to the last cell.
    for (int a = 'h1F; a <= 'hFF; a++) send(TXT_CHAR, code_of(a));
    chk("fill_full", 32'(full), 1);
    chk("fill_cursor", 32'(cursor_xy), 8'hFF);
    rd(8'hFF, code_of('hFF), "rd_FF_filled");
    rd(8'h80, code_of('h80), "rd_80_filled");
    send(TXT_NL, 7'h00);
    chk("nl_full_cursor", 32'(cursor_xy), 8'hFF);
    chk("nl_full_flag", 32'(full), 1);
    send(TXT_CHAR, 7'h7E);
    chk("drop_cursor", 32'(cursor_xy), 8'hFF);
    rd(8'hFF, code_of('hFF), "drop_rd_FF");
    send(TXT_BS, 7'h00);
    chk("bs_full_flag", 32'(full), 0);
    chk("bs_full_cursor", 32'(cursor_xy), 8'hFF);
    rd(8'hFF, SPACE, "bs_full_rd_FF");

    // Clear sweep with ignored requests during it.
    send(TXT_CLR, 7'h00);
    chk("clr_ready", 32'(wr_ready), 0);
    chk("clr_cursor", 32'(cursor_xy), 0);
    count_busy(1'b1, n);
    chk("clr_sweep_len", 32'(n), 256);
    chk("clr_cursor_after", 32'(cursor_xy), 0);
    chk("clr_full_after", 32'(full), 0);
    for (int a = 0; a < 256; a++) rd(8'(a), SPACE, "clr_cell");
    send(TXT_BS, 7'h00);
    chk("bs_at_00", 32'(cursor_xy), 0);
    rd(8'h00, SPACE, "bs_at_00_rd");

    // Asynchronous reset while idle with the cursor moved.
    send(TXT_CHAR, 7'h41);
    send(TXT_CHAR, 7'h42);
    send(TXT_CHAR, 7'h43);
    chk("pre_rst_cursor", 32'(cursor_xy), 8'h03);
    rst = 1'b1;
    #1;
    chk("arst_idle_cursor", 32'(cursor_xy), 0);
    chk("arst_idle_busy", 32'(busy), 1);
    chk("arst_idle_ready", 32'(wr_ready), 0);
    @(posedge clk); #1 rst = 1'b0;
    count_busy(1'b0, n);
    chk("arst_idle_sweep", 32'(n), 256);
    rd(8'h01, SPACE, "arst_idle_rd_01");

    // Asynchronous reset at sweep count 100.
    char_xy = 8'h00;
    send(TXT_CHAR, 7'h51);
    send(TXT_CLR, 7'h00);
    repeat (100) tick();
    chk("mid_sweep_code", 32'(char_code), 32'(SPACE));
    chk("mid_sweep_busy", 32'(busy), 1);
    rst = 1'b1;
    #1;
    chk("arst_sweep_code", 32'(char_code), 0);
    chk("arst_sweep_busy", 32'(busy), 1);
    chk("arst_sweep_ready", 32'(wr_ready), 0);
    chk("arst_sweep_full", 32'(full), 0);
    @(posedge clk); #1 rst = 1'b0;
    count_busy(1'b0, n);
    chk("arst_sweep_len", 32'(n), 256);
    rd(8'hC8, SPACE, "arst_sweep_rd_C8");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
